// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the select lines of a shared 4:1 mux
//
// Purpose:
//   Four requesters share one 4:1 mux (i0..i3 -> y). Requester i owns mux input i
//   while it holds the grant. A grant is kept until its owner releases i_req. Ownership
//   then passes in round-robin order, starting the search just after the last winner.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - an owner is forced to give up the grant after MAX_HOLD consecutive
//               cycles, but only if another requester is waiting.
//   undefined - there is no hold counter. An owner keeps the grant while it requests.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner (ARB_TIMEOUT_EN only)
//   CNT_W     hold-counter width, 2**CNT_W >= MAX_HOLD (ARB_TIMEOUT_EN only)
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous, active-high reset
//   i_req    [3:0] request per mux input
//   i_en     arbitration enable; 0 blocks new grants and hand-overs, never revokes
//   o_gnt    [3:0] registered one-hot grant (or zero)
//   o_sel    [1:0] registered mux select; o_sel[1] -> s1, o_sel[0] -> s0
//   o_valid  high while a grant is active

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_en,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_valid
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt,   w_gnt_nxt;
  logic [1:0] r_sel,   w_sel_nxt;
  logic [1:0] r_last,  w_last_nxt;
  logic       r_valid, w_valid_nxt;

  logic [3:0] w_others;
  logic       w_owner_req;
  logic [1:0] w_pick_all;
  logic [1:0] w_pick_oth;
  logic       w_expired;
  logic       w_rotate;

  // Round-robin pick: scan base+1, base+2, base+3, then base itself (mod 4).
  // The first set bit wins. The caller only uses the result when r is non-zero.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // In GRANT, r_last always equals the owner index. Searching the masked requests from
  // r_last therefore excludes the owner and starts at owner+1.
  assign w_others    = i_req & ~r_gnt;
  assign w_owner_req = |(i_req & r_gnt);
  assign w_pick_all  = rr_pick(i_req, r_last);
  assign w_pick_oth  = rr_pick(w_others, r_last);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_expired = (r_cnt == LP_CNT_MAX);
`else
  assign w_expired = 1'b0;
`endif

  // The owner offers the grant when it releases its request or its hold time is used up.
  // The grant actually moves only if someone else is waiting and i_en is set.
  assign w_rotate = !w_owner_req || w_expired;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_en && (|i_req)) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_pick_all;
          w_sel_nxt   = w_pick_all;
          w_last_nxt  = w_pick_all;
          w_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end

      ST_GRANT: begin
        if (w_rotate && i_en && (|w_others)) begin
          // Hand over on the same edge, so valid has no gap.
          w_gnt_nxt   = 4'b0001 << w_pick_oth;
          w_sel_nxt   = w_pick_oth;
          w_last_nxt  = w_pick_oth;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end else if (!w_owner_req) begin
          // Release with nobody eligible. sel keeps the last granted index.
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_valid_nxt = 1'b0;
        end else begin
`ifdef ARB_TIMEOUT_EN
          // Saturate at the limit. A later requester then takes over at the next edge.
          if (!w_expired) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`endif
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // r_last resets to 3 so that input 0 wins the first arbitration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_last  <= 2'd3;
      r_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign o_gnt   = r_gnt;
  assign o_sel   = r_sel;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

  int n_tests;
  int n_fail;

  mux4_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (2)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_en    (en),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are sampled and inputs are driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev);
    n_tests++;
    assert (gnt === eg) else begin
      n_fail++;
      $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
    end
    n_tests++;
    assert (sel === es) else begin
      n_fail++;
      $error("FAIL %s sel: observed %b expected %b", tag, sel, es);
    end
    n_tests++;
    assert (valid === ev) else begin
      n_fail++;
      $error("FAIL %s valid: observed %b expected %b", tag, valid, ev);
    end
  endtask

  initial begin
    logic [3:0] eg;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = 4'b0000;
    en  = 1'b0;
    tick();
    tick();
    check("reset", 4'b0000, 2'b00, 1'b0);
    rst = 1'b0;

    // 1: single requester, one-edge latency
    req = 4'b0001;
    en  = 1'b1;
    check("t1_before_edge", 4'b0000, 2'b00, 1'b0);
    tick();
    check("t1_grant", 4'b0001, 2'b00, 1'b1);
    req = 4'b0000;
    tick();
    check("t1_release", 4'b0000, 2'b00, 1'b0);

    // Reset again so that arbitration restarts from input 0
    rst = 1'b1;
    #2;
    rst = 1'b0;

    // 2: all requesting; each owner drops 2 cycles after its grant -> 0,1,2,3,0
    req = 4'b1111;
    tick();
    for (int o = 0; o < 4; o++) begin
      eg = 4'b0001 << o;
      check("t2_granted", eg, 2'(o), 1'b1);
      req = 4'b1111;
      tick();
      check("t2_hold", eg, 2'(o), 1'b1);
      req = 4'b1111 & ~eg;
      tick();
    end
    check("t2_wrap", 4'b0001, 2'b00, 1'b1);

    // 3: owner 0 drops -> 2; owner 2 drops with 1001 pending -> 3; then -> 0
    req = 4'b0100;
    tick();
    check("t3_to2", 4'b0100, 2'b10, 1'b1);
    req = 4'b1001;
    tick();
    check("t3_3_before_0", 4'b1000, 2'b11, 1'b1);
    req = 4'b0001;
    tick();
    check("t3_to0", 4'b0001, 2'b00, 1'b1);

    // 4: en=0 blocks new grants
    req = 4'b0000;
    tick();
    check("t4_idle", 4'b0000, 2'b00, 1'b0);
    en  = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_blocked", 4'b0000, 2'b00, 1'b0);
    end
    en = 1'b1;
    tick();
    check("t4_enabled", 4'b0100, 2'b10, 1'b1);
    // en=0 keeps the existing grant but blocks the hand-over
    en = 1'b0;
    tick();
    check("t4_en0_hold", 4'b0100, 2'b10, 1'b1);
    req = 4'b1000;
    tick();
    check("t4_en0_no_handover", 4'b0000, 2'b10, 1'b0);
    en = 1'b1;
    tick();
    check("t4_resume", 4'b1000, 2'b11, 1'b1);

    // 5: asynchronous reset mid-grant
    req = 4'b0010;
    tick();
    check("t5_grant1", 4'b0010, 2'b01, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_rst", 4'b0000, 2'b00, 1'b0);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("t5_restart", 4'b0001, 2'b00, 1'b1);

    // 6: steady 0011 with owner 0 already granted
    req = 4'b0011;
    for (int t = 1; t <= 12; t++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      if (((t / 4) % 2) == 0) check("t6_timeout", 4'b0001, 2'b00, 1'b1);
      else                    check("t6_timeout", 4'b0010, 2'b01, 1'b1);
`else
      check("t6_hold", 4'b0001, 2'b00, 1'b1);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
